crc_ram_reader: RTL and testbench
=================================

CRC_RAM_READER -- requirements
Module: crc_ram_reader

Interface
REQ-001 SHALL have parameter SIZE, default 32'd12, meaning log2 of RAM size in bytes; word address width is SIZE-2.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block has one clock only.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  begin a CRC job; sampled only in IDLE.
REQ-005 SHALL have port base_addr  input  SIZE-2  first word address of the buffer; sampled with start.
REQ-006 SHALL have port len_bytes  input  SIZE+1  buffer length in bytes; sampled with start.
REQ-007 SHALL have port hold  input  1  arbitration stall; while 1, no new RAM read is issued.
REQ-008 SHALL have port ram_ren  output  1  RAM read enable (drives RAM ren; RAM we is tied 0 externally).
REQ-009 SHALL have port ram_addr  output  SIZE-2  RAM word address.
REQ-010 SHALL have port ram_din  input  `WIDTH  RAM read data, valid in the cycle after ram_ren=1 and stable until the next read.
REQ-011 SHALL have port busy  output  1  job in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when crc_out is final.
REQ-013 SHALL have port crc_out  output  32  CRC result.

Function
REQ-014 CRC SHALL be CRC-32/IEEE reflected: poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
REQ-015 Byte order within a word SHALL be ram_din[7:0] first, then [15:8], [23:16], [31:24].
REQ-016 Words processed SHALL be ceil(len_bytes/4); the last word SHALL contribute only len_bytes[1:0] low bytes, or all 4 when len_bytes[1:0]=0.
REQ-017 FSM states SHALL be IDLE, READ, LAST, FINISH.
REQ-018 IDLE and start=1 and len_bytes=0 SHALL go to FINISH; crc_out=0x00000000.
REQ-019 IDLE and start=1 and len_bytes>0 SHALL latch inputs, set the CRC register to 0xFFFFFFFF, set busy=1, and go to READ.
REQ-020 In READ with hold=0, the block SHALL assert ram_ren=1 with ram_addr = base_addr + word index, one word per cycle.
REQ-021 In READ with hold=1, ram_ren SHALL be 0, and the word index and the next address SHALL NOT advance.
REQ-022 The word read in cycle t SHALL be folded into the CRC register in cycle t+1, whether or not hold is asserted in t+1; throughput is one word per clock.
REQ-023 After the last word is issued, the FSM SHALL go to LAST, in which the final word is folded in and ram_ren=0.
REQ-024 LAST SHALL go to FINISH; in FINISH, crc_out SHALL equal the final-XORed CRC, done=1 for exactly one cycle, and busy=0; the FSM then returns to IDLE.
REQ-025 With no hold, done SHALL rise N+2 cycles after the start sample edge, where N is the word count; each hold cycle in READ SHALL add exactly one cycle.
REQ-026 Address arithmetic SHALL be modulo 2**(SIZE-2), so reads wrap from the top word to word 0.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 crc_out SHALL hold its value from FINISH until the next job's FINISH.
REQ-029 ram_ren SHALL be 0 in IDLE, LAST, and FINISH.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, ram_ren=0, ram_addr=0, crc_out=0x00000000, and the CRC register to 0xFFFFFFFF.
REQ-031 Reset mid-job SHALL abandon the job with no done pulse; the first start after release SHALL behave as from power-up.

Verification
REQ-032 RAM words 0x34333231, 0x38373635, 0x00000039 at address 0, start with base 0, len 9 -> 3 consecutive ram_ren cycles at addresses 0,1,2; done 5 cycles after start; crc_out=0xCBF43926.
REQ-033 Same buffer as REQ-032 with hold=1 for 2 cycles after the first read -> identical crc_out 0xCBF43926; done 7 cycles after start.
REQ-034 Word 0x00000061 with len 1 -> crc_out=0xE8B7BE43; len 0 -> no ram_ren, done 1 cycle after start, crc_out=0x00000000.
REQ-035 SIZE=12, base 1023, len 8 -> reads at addresses 1023 then 0; CRC equals that of the same 8 bytes stored at addresses 0 and 1.
REQ-036 rst_n low during READ of a 9-byte job -> outputs at reset values immediately and no done pulse; a fresh REQ-032 job after release -> 0xCBF43926.
REQ-037 start pulsed while busy -> ignored; the running job's crc_out is unaffected.

Source files
------------

// File: rtl/crc_ram_reader_if.sv
// rtl/crc_ram_reader_if.sv - RAM read port between the CRC reader and a word-wide RAM
`ifndef WIDTH
`define WIDTH 32
`endif

interface crc_ram_reader_if #(
  parameter int unsigned SIZE = 32'd12
) ();
  logic                ram_ren;
  logic [SIZE-3:0]     ram_addr;
  logic [`WIDTH-1:0]   ram_din;

  modport master (output ram_ren, output ram_addr, input ram_din);
  modport slave  (input ram_ren, input ram_addr, output ram_din);
endinterface

// File: rtl/crc_ram_reader.sv
// rtl/crc_ram_reader.sv - streams a RAM buffer one word per clock through a reflected CRC-32
`ifndef WIDTH
`define WIDTH 32
`endif

module crc_ram_reader #(
  parameter int unsigned SIZE = 32'd12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SIZE-3:0]     base_addr,
  input  logic [SIZE:0]       len_bytes,
  input  logic                hold,
  crc_ram_reader_if.master    ram,
  output logic                busy,
  output logic                done,
  output logic [31:0]         crc_out
);

  localparam logic [31:0] POLY = 32'hEDB88320;

  typedef enum logic [1:0] {IDLE, READ, LAST, FINISH} state_t;

  state_t            state_q, state_d;
  logic [SIZE-3:0]   addr_q;
  logic [SIZE-1:0]   words_left_q;
  logic [1:0]        tail_q;
  logic              pend_q, pend_last_q;
  logic [31:0]       crc_q;
  logic              issue, issue_last;
  logic [2:0]        fold_bytes;
  logic [31:0]       crc_folded;
  logic [SIZE+1:0]   len_plus3;
  logic [SIZE-1:0]   word_count;

  function automatic logic [31:0] crc_fold(input logic [31:0] crc, input logic [31:0] data,
                                           input logic [2:0] nbytes);
    logic [31:0] c;
    c = crc;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nbytes) begin
        c = c ^ {24'd0, data[8*b +: 8]};
        for (int k = 0; k < 8; k++) begin
          c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  assign len_plus3  = {1'b0, len_bytes} + (SIZE+2)'(3);
  assign word_count = len_plus3[SIZE+1:2];

  assign issue      = (state_q == READ) && !hold;
  assign issue_last = issue && (words_left_q == SIZE'(1));

  // Only the final word of a job may be partial; a zero remainder means all four bytes.
  assign fold_bytes = (pend_last_q && (tail_q != 2'd0)) ? {1'b0, tail_q} : 3'd4;
  assign crc_folded = crc_fold(crc_q, ram.ram_din, fold_bytes);

  assign ram.ram_addr = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len_bytes == '0) ? FINISH : READ;
      READ:    if (issue_last) state_d = LAST;
      LAST:    state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram.ram_ren = issue;
    busy        = (state_q == READ) || (state_q == LAST);
    done        = (state_q == FINISH);
  end

  // The word issued last cycle is folded now, independent of hold in this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      words_left_q <= '0;
      tail_q       <= '0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      crc_q        <= 32'hFFFFFFFF;
      crc_out      <= 32'h0;
    end else begin
      pend_q      <= issue;
      pend_last_q <= issue_last;
      if (state_q == IDLE && start) begin
        addr_q       <= base_addr;
        words_left_q <= word_count;
        tail_q       <= len_bytes[1:0];
        crc_q        <= 32'hFFFFFFFF;
        if (len_bytes == '0) crc_out <= 32'h0;
      end else begin
        if (issue) begin
          addr_q       <= addr_q + (SIZE-2)'(1);
          words_left_q <= words_left_q - SIZE'(1);
        end
        if (pend_q) crc_q <= crc_folded;
        if (state_q == LAST) crc_out <= ~crc_folded;
      end
    end
  end

endmodule

// File: tb/tb_crc_ram_reader.sv
// tb/tb_crc_ram_reader.sv - table-driven bench with CRC scoreboard for crc_ram_reader
module tb_crc_ram_reader;
  localparam int SIZE = 12;
  localparam int WORDS = 1 << (SIZE - 2);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            hold = 1'b0;
  logic [SIZE-3:0] base_addr = '0;
  logic [SIZE:0]   len_bytes = '0;
  logic            busy, done;
  logic [31:0]     crc_out;

  crc_ram_reader_if #(.SIZE(SIZE)) ram_if ();

  crc_ram_reader #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len_bytes (len_bytes),
    .hold      (hold),
    .ram       (ram_if),
    .busy      (busy),
    .done      (done),
    .crc_out   (crc_out)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:WORDS-1];

  always @(posedge clk) begin
    if (ram_if.ram_ren) ram_if.ram_din <= mem[ram_if.ram_addr];
  end

  typedef struct {
    int          base;
    int          len;
    logic [31:0] mask;
    bit          pulse;
    bit          use_model;
    logic [31:0] crc;
    int          lat;
  } vec_t;

  vec_t            vecs [9];
  logic [31:0]     sb_q [$];
  logic [SIZE-3:0] addr_exp_q [$];
  int              n_vec = 0;
  int              n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_crc(input int base, input int len);
    logic [31:0] c, w;
    logic [7:0]  b;
    if (len == 0) return 32'h0;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      w = mem[(base + i / 4) % WORDS];
      b = w[8 * (i % 4) +: 8];
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic run_job(input vec_t v);
    int          cyc, nren, nwords;
    bit          seen;
    logic [31:0] exp_crc;
    nwords  = (v.len + 3) / 4;
    exp_crc = v.use_model ? model_crc(v.base, v.len) : v.crc;
    sb_q.push_back(exp_crc);
    for (int i = 0; i < nwords; i++) addr_exp_q.push_back((SIZE-2)'((v.base + i) % WORDS));
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = (SIZE-2)'(v.base);
    len_bytes = (SIZE+1)'(v.len);
    hold      = 1'b0;
    @(posedge clk);
    cyc  = 1;
    nren = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      #1;
      start = v.pulse && (cyc == 2);
      if (v.pulse && cyc == 2) begin
        base_addr = (SIZE-2)'(10);
        len_bytes = (SIZE+1)'(1);
      end
      hold = (cyc < 32) ? v.mask[cyc] : 1'b0;
      @(negedge clk);
      if (cyc == 1) check("busy after start", {31'd0, busy}, {31'd0, v.len > 0});
      if (ram_if.ram_ren) begin
        nren++;
        if (addr_exp_q.size() > 0) check("ram_addr", {22'd0, ram_if.ram_addr}, {22'd0, addr_exp_q.pop_front()});
      end
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    hold  = 1'b0;
    check("done seen", {31'd0, seen}, 32'd1);
    check("done latency", cyc, v.lat);
    check("ram_ren count", nren, nwords);
    if (seen && sb_q.size() > 0) check("crc_out", crc_out, sb_q.pop_front());
    sb_q.delete();
    addr_exp_q.delete();
    @(negedge clk);
    check("done one cycle", {31'd0, done}, 32'd0);
    check("busy after done", {31'd0, busy}, 32'd0);
    check("crc_out held", crc_out, exp_crc);
  endtask

  initial begin
    bit saw_done;
    for (int i = 0; i < WORDS; i++) mem[i] = 32'(i) * 32'h9E3779B1 + 32'h01234567;
    mem[0]    = 32'h34333231;
    mem[1]    = 32'h38373635;
    mem[2]    = 32'h00000039;
    mem[10]   = 32'h00000061;
    mem[1023] = 32'hDEADBEEF;

    vecs[0] = '{0,    9,  32'h0,  1'b0, 1'b0, 32'hCBF43926, 5};
    vecs[1] = '{0,    9,  32'hC,  1'b0, 1'b0, 32'hCBF43926, 7};
    vecs[2] = '{10,   1,  32'h0,  1'b0, 1'b0, 32'hE8B7BE43, 3};
    vecs[3] = '{0,    0,  32'h0,  1'b0, 1'b0, 32'h00000000, 1};
    vecs[4] = '{1023, 8,  32'h0,  1'b0, 1'b1, 32'h0,        4};
    vecs[5] = '{20,   13, 32'h14, 1'b0, 1'b1, 32'h0,        8};
    vecs[6] = '{40,   6,  32'h0,  1'b0, 1'b1, 32'h0,        4};
    vecs[7] = '{100,  16, 32'h0,  1'b1, 1'b1, 32'h0,        6};
    vecs[8] = '{10,   2,  32'h0,  1'b0, 1'b1, 32'h0,        3};

    repeat (3) @(negedge clk);
    check("reset crc_out", crc_out, 32'h0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset ram_ren", {31'd0, ram_if.ram_ren}, 32'd0);
    check("reset ram_addr", {22'd0, ram_if.ram_addr}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_job(vecs[i]);

    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = '0;
    len_bytes = (SIZE+1)'(9);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("busy before reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-job reset ram_ren", {31'd0, ram_if.ram_ren}, 32'd0);
    check("mid-job reset busy", {31'd0, busy}, 32'd0);
    check("mid-job reset done", {31'd0, done}, 32'd0);
    check("mid-job reset ram_addr", {22'd0, ram_if.ram_addr}, 32'd0);
    check("mid-job reset crc_out", crc_out, 32'h0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    check("no done after reset", {31'd0, saw_done}, 32'd0);
    run_job(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
